// File: rtl/ysyx_22041412_ctrl_pkg.sv
// Shared constants for the ysyx_22041412 multicycle control path: FSM state codes,
// the default reset PC and opcode constants also used by the decoder.
package ysyx_22041412_ctrl_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_COMMIT = 3'd5;
   localparam logic [2:0] ST_HALT   = 3'd6;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   // States in which the sequencer is blocked on an external memory response.
   function automatic logic is_wait_state(input logic [2:0] st);
      return (st == ST_FETCH) || (st == ST_MEM);
   endfunction

endpackage

// File: rtl/ysyx_22041412_wait_timer.sv
// 8-bit wait counter for memory handshakes. Counts while run_i is high, clears on
// clear_i, and flags expire_o in the cycle that would complete limit_i waits.
module ysyx_22041412_wait_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       run_i,
   input  logic [7:0] limit_i,
   output logic       expire_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the waits already elapsed, so this cycle is wait number cnt_q+1.
   assign expire_o = run_i && (cnt_q == (limit_i - 8'd1));

endmodule

// File: rtl/ysyx_22041412_multicycle_ctrl.sv
// Multicycle sequencer and PC owner: FETCH->DECODE->EXEC->(MEM)->WB->COMMIT, HALT on
// ebreak or memory timeout. Define YSYX_22041412_DIFFTEST_EN to add commit trace ports.
module ysyx_22041412_multicycle_ctrl
   import ysyx_22041412_ctrl_pkg::*;
#(
   parameter int unsigned          XLEN     = 64,
   parameter logic [XLEN-1:0]      RESET_PC = XLEN'(DEFAULT_RESET_PC),
   parameter int unsigned          ILEN     = 32,
   parameter int unsigned          MEM_TMO  = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic [ILEN-1:0] inst,
   input  logic            mem_op,
   output logic            dmem_req,
   input  logic            dmem_ack,
   input  logic            jump_en,
   input  logic [XLEN-1:0] jump_target,
   input  logic            rd_wen_dec,
   output logic            reg_wen,
   input  logic            is_ebreak,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] npc,
   output logic            commit,
   output logic            halted,
   output logic            trap,
   output logic [2:0]      dbg_state
`ifdef YSYX_22041412_DIFFTEST_EN
   ,
   output logic [XLEN-1:0] commit_pc,
   output logic [ILEN-1:0] commit_inst,
   output logic [XLEN-1:0] commit_npc
`endif
);

   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TMO);

   // Handshake rule: a request is held high for the whole state and the first cycle
   // with the matching valid/ack (sampled at the clock edge) completes the transfer.
   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, npc_q, npc_w;
   logic [ILEN-1:0] inst_q;
   logic            trap_q, trap_d;
   logic            mem_resp, tmr_run, tmr_clear, tmr_expire;

   assign npc_w    = jump_en ? jump_target : pc_q + XLEN'(4);
   assign mem_resp = (state_q == ST_FETCH) ? imem_rvalid : dmem_ack;
   assign tmr_run  = is_wait_state(state_q) && !mem_resp;

   always_comb begin
      state_d = state_q;
      trap_d  = trap_q;
      case (state_q)
         ST_FETCH, ST_MEM: begin
            if (mem_resp) begin
               state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_WB;
            end else if (tmr_expire) begin
               state_d = ST_HALT;
               trap_d  = 1'b1;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = mem_op ? ST_MEM : ST_WB;
         ST_WB:     state_d = ST_COMMIT;
         ST_COMMIT: state_d = is_ebreak ? ST_HALT : ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
   end

   assign tmr_clear = (state_d != state_q);

   ysyx_22041412_wait_timer u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (tmr_clear),
      .run_i    (tmr_run),
      .limit_i  (TMO_LIMIT),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         npc_q   <= RESET_PC;
         inst_q  <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         trap_q  <= trap_d;
         if (state_q == ST_FETCH && imem_rvalid) begin
            inst_q <= imem_rdata;
         end
         if (state_q == ST_EXEC) begin
            npc_q <= npc_w;
         end
         if (state_q == ST_COMMIT) begin
            pc_q <= npc_q;
         end
      end
   end

`ifdef YSYX_22041412_DIFFTEST_EN
   logic [XLEN-1:0] commit_pc_q, commit_npc_q;
   logic [ILEN-1:0] commit_inst_q;

   // Loaded on the way into COMMIT so the trace is valid in the same cycle as commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         commit_pc_q   <= '0;
         commit_inst_q <= '0;
         commit_npc_q  <= '0;
      end else if (state_q == ST_WB) begin
         commit_pc_q   <= pc_q;
         commit_inst_q <= inst_q;
         commit_npc_q  <= npc_q;
      end
   end

   assign commit_pc   = commit_pc_q;
   assign commit_inst = commit_inst_q;
   assign commit_npc  = commit_npc_q;
`endif

   assign imem_req  = (state_q == ST_FETCH);
   assign imem_addr = pc_q;
   assign inst      = inst_q;
   assign dmem_req  = (state_q == ST_MEM);
   assign reg_wen   = (state_q == ST_WB) && rd_wen_dec;
   assign pc        = pc_q;
   assign npc       = npc_w;
   assign commit    = (state_q == ST_COMMIT);
   assign halted    = (state_q == ST_HALT);
   assign trap      = trap_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_22041412_multicycle_ctrl.sv
// Directed bench for ysyx_22041412_multicycle_ctrl: reset, ALU/jump/memory instructions,
// timeout trap, ebreak halt and reset during a memory access.
module tb_ysyx_22041412_multicycle_ctrl;

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        mem_op;
   logic        dmem_req;
   logic        dmem_ack;
   logic        jump_en;
   logic [63:0] jump_target;
   logic        rd_wen_dec;
   logic        reg_wen;
   logic        is_ebreak;
   logic [63:0] pc;
   logic [63:0] npc;
   logic        commit;
   logic        halted;
   logic        trap;
   logic [2:0]  dbg_state;
`ifdef YSYX_22041412_DIFFTEST_EN
   logic [63:0] commit_pc;
   logic [31:0] commit_inst;
   logic [63:0] commit_npc;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ysyx_22041412_multicycle_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .mem_op      (mem_op),
      .dmem_req    (dmem_req),
      .dmem_ack    (dmem_ack),
      .jump_en     (jump_en),
      .jump_target (jump_target),
      .rd_wen_dec  (rd_wen_dec),
      .reg_wen     (reg_wen),
      .is_ebreak   (is_ebreak),
      .pc          (pc),
      .npc         (npc),
      .commit      (commit),
      .halted      (halted),
      .trap        (trap),
      .dbg_state   (dbg_state)
`ifdef YSYX_22041412_DIFFTEST_EN
      ,
      .commit_pc   (commit_pc),
      .commit_inst (commit_inst),
      .commit_npc  (commit_npc)
`endif
   );

   // Runs one instruction from a FETCH negedge until commit (bounded), then one more
   // cycle so the caller sees the retired PC. dmem_ack is raised after ack_delay waits.
   task automatic run_one(input int ack_delay, output int cyc, output int wen_cnt,
                          output int wen_cyc, output int dreq_cnt, output int commits);
      cyc = 0; wen_cnt = 0; wen_cyc = -1; dreq_cnt = 0; commits = 0;
      while (commits == 0 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (dmem_req) begin
            dreq_cnt++;
            dmem_ack = (dreq_cnt > ack_delay);
         end else begin
            dmem_ack = 1'b0;
         end
         if (reg_wen) begin
            wen_cnt++;
            wen_cyc = cyc;
         end
         if (commit) commits++;
      end
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; mem_op = 1'b0; dmem_ack = 1'b0;
      jump_en = 1'b0; jump_target = '0; rd_wen_dec = 1'b0; is_ebreak = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (pc !== 64'h8000_0000) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, 64'h8000_0000); end
      tests++; if (imem_addr !== 64'h8000_0000) begin fails++; $display("FAIL reset_imem_addr got %h exp %h", imem_addr, 64'h8000_0000); end
      tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h exp 0", inst); end
      tests++; if (dbg_state !== S_FETCH) begin fails++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_FETCH); end
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_imem_req got %b exp 1", imem_req); end
      tests++; if ({dmem_req, reg_wen, commit, halted, trap} !== 5'b0) begin
         fails++; $display("FAIL reset_strobes got %b exp 00000", {dmem_req, reg_wen, commit, halted, trap});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_addi_stream();
      int cyc, wen_cnt, wen_cyc, dreq, commits;
      logic [31:0] word;
      imem_rvalid = 1'b1; rd_wen_dec = 1'b1; mem_op = 1'b0; jump_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         word = 32'h0000_0093 | (32'(k + 1) << 20);
         imem_rdata = word;
         run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
         tests++; if (commits !== 1) begin fails++; $display("FAIL addi%0d_commits got %0d exp 1", k, commits); end
         tests++; if (cyc !== 4) begin fails++; $display("FAIL addi%0d_latency got %0d exp 4", k, cyc); end
         tests++; if (wen_cnt !== 1 || wen_cyc !== 3) begin
            fails++; $display("FAIL addi%0d_reg_wen got cnt %0d cyc %0d exp cnt 1 cyc 3", k, wen_cnt, wen_cyc);
         end
         tests++; if (inst !== word) begin fails++; $display("FAIL addi%0d_inst got %h exp %h", k, inst, word); end
         tests++; if (pc !== 64'h8000_0004 + 64'(4 * k)) begin
            fails++; $display("FAIL addi%0d_pc got %h exp %h", k, pc, 64'h8000_0004 + 64'(4 * k));
         end
`ifdef YSYX_22041412_DIFFTEST_EN
         tests++; if (commit_pc !== 64'h8000_0000 + 64'(4 * k)) begin
            fails++; $display("FAIL addi%0d_commit_pc got %h exp %h", k, commit_pc, 64'h8000_0000 + 64'(4 * k));
         end
         tests++; if (commit_inst !== word) begin fails++; $display("FAIL addi%0d_commit_inst got %h exp %h", k, commit_inst, word); end
`endif
      end
   endtask

   task automatic test_jal();
      int cyc, wen_cnt, wen_cyc, dreq, commits;
      imem_rdata = 32'h1000_00EF; jump_en = 1'b1; jump_target = 64'h8000_0100; rd_wen_dec = 1'b1;
      run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (pc !== 64'h8000_0100) begin fails++; $display("FAIL jal_pc got %h exp %h", pc, 64'h8000_0100); end
      tests++; if (wen_cnt !== 1 || wen_cyc !== 3) begin
         fails++; $display("FAIL jal_reg_wen got cnt %0d cyc %0d exp cnt 1 cyc 3", wen_cnt, wen_cyc);
      end
      jump_target = 64'hFFFF_FFFF_FFFF_FFFE;
      run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++; $display("FAIL jal_unaligned_pc got %h exp %h", pc, 64'hFFFF_FFFF_FFFF_FFFE); end
      jump_en = 1'b0;
      #1;
      tests++; if (npc !== 64'h0000_0000_0000_0002) begin fails++; $display("FAIL npc_wrap got %h exp 2", npc); end
      imem_rdata = 32'h0000_0093;
      run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (pc !== 64'h2) begin fails++; $display("FAIL wrap_pc got %h exp 2", pc); end
   endtask

   task automatic test_mem();
      int cyc, wen_cnt, wen_cyc, dreq, commits;
      mem_op = 1'b1; rd_wen_dec = 1'b1; imem_rdata = 32'h0000_3083;
      run_one(3, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (dreq !== 4) begin fails++; $display("FAIL load_dmem_req_cycles got %0d exp 4", dreq); end
      tests++; if (cyc !== 8 || commits !== 1) begin fails++; $display("FAIL load_latency got %0d/%0d exp 8/1", cyc, commits); end
      tests++; if (wen_cnt !== 1 || wen_cyc !== 7) begin
         fails++; $display("FAIL load_reg_wen got cnt %0d cyc %0d exp cnt 1 cyc 7", wen_cnt, wen_cyc);
      end
      tests++; if (pc !== 64'h6) begin fails++; $display("FAIL load_pc got %h exp 6", pc); end
      rd_wen_dec = 1'b0; imem_rdata = 32'h0010_3023;
      run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (dreq !== 1 || cyc !== 5) begin fails++; $display("FAIL store_fast_ack got req %0d cyc %0d exp 1 5", dreq, cyc); end
      tests++; if (wen_cnt !== 0) begin fails++; $display("FAIL store_reg_wen got %0d exp 0", wen_cnt); end
      tests++; if (pc !== 64'hA) begin fails++; $display("FAIL store_pc got %h exp a", pc); end
      mem_op = 1'b0;
   endtask

   task automatic test_timeout();
      int cyc = 0, trap_cyc = -1, commits = 0;
      logic req_254 = 1'b0;
      imem_rvalid = 1'b0;
      while (trap_cyc < 0 && cyc < 300) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (commit) commits++;
         if (cyc == 254) req_254 = imem_req;
         if (trap) trap_cyc = cyc;
      end
      tests++; if (trap_cyc !== 255) begin fails++; $display("FAIL tmo_cycle got %0d exp 255", trap_cyc); end
      tests++; if (req_254 !== 1'b1) begin fails++; $display("FAIL tmo_req_held got %b exp 1", req_254); end
      tests++; if (halted !== 1'b1 || dbg_state !== S_HALT || imem_req !== 1'b0) begin
         fails++; $display("FAIL tmo_halt got halted %b state %0d req %b exp 1 6 0", halted, dbg_state, imem_req);
      end
      imem_rvalid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (commit) commits++;
      end
      tests++; if (commits !== 0) begin fails++; $display("FAIL tmo_no_commit got %0d exp 0", commits); end
      tests++; if (pc !== 64'hA || trap !== 1'b1 || dbg_state !== S_HALT) begin
         fails++; $display("FAIL tmo_sticky got pc %h trap %b state %0d exp a 1 6", pc, trap, dbg_state);
      end
   endtask

   task automatic test_ebreak();
      int cyc, wen_cnt, wen_cyc, dreq, commits;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tests++; if (trap !== 1'b0 || halted !== 1'b0 || pc !== 64'h8000_0000) begin
         fails++; $display("FAIL rst_after_trap got trap %b halted %b pc %h", trap, halted, pc);
      end
      is_ebreak = 1'b1; rd_wen_dec = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
      run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (commits !== 1 || cyc !== 4) begin fails++; $display("FAIL ebreak_commit got %0d at %0d exp 1 at 4", commits, cyc); end
      tests++; if (halted !== 1'b1 || pc !== 64'h8000_0004 || imem_req !== 1'b0) begin
         fails++; $display("FAIL ebreak_halt got halted %b pc %h req %b", halted, pc, imem_req);
      end
      imem_rdata = 32'hDEAD_BEEF;
      commits = 0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (commit) commits++;
      end
      tests++; if (inst !== 32'h0010_0073 || commits !== 0) begin
         fails++; $display("FAIL ebreak_ignore_rvalid got inst %h commits %0d", inst, commits);
      end
      rst_n = 1'b0; is_ebreak = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tests++; if (pc !== 64'h8000_0000 || dbg_state !== S_FETCH || halted !== 1'b0 || inst !== 32'h0) begin
         fails++; $display("FAIL ebreak_reset got pc %h state %0d halted %b inst %h", pc, dbg_state, halted, inst);
      end
   endtask

   task automatic test_reset_in_mem();
      int cyc, wen_cnt, wen_cyc, dreq, commits;
      int bad = 0;
      mem_op = 1'b1; rd_wen_dec = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_3103; dmem_ack = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         if (reg_wen || commit) bad++;
      end
      tests++; if (dbg_state !== S_MEM || dmem_req !== 1'b1) begin
         fails++; $display("FAIL rim_in_mem got state %0d req %b exp 3 1", dbg_state, dmem_req);
      end
      @(posedge clk);
      @(negedge clk);
      if (reg_wen || commit) bad++;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (reg_wen || commit) bad++;
      rst_n = 1'b1;
      tests++; if (bad !== 0) begin fails++; $display("FAIL rim_no_wb got %0d strobes exp 0", bad); end
      tests++; if (pc !== 64'h8000_0000 || dbg_state !== S_FETCH || dmem_req !== 1'b0) begin
         fails++; $display("FAIL rim_reset got pc %h state %0d dreq %b", pc, dbg_state, dmem_req);
      end
      mem_op = 1'b0;
      run_one(0, cyc, wen_cnt, wen_cyc, dreq, commits);
      tests++; if (commits !== 1 || pc !== 64'h8000_0004) begin
         fails++; $display("FAIL rim_resume got commits %0d pc %h exp 1 80000004", commits, pc);
      end
   endtask

   initial begin
      test_reset();
      test_addi_stream();
      test_jal();
      test_mem();
      test_timeout();
      test_ebreak();
      test_reset_in_mem();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
